// File: rtl/tpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tpu_pkg
// Brief    : Shared loader state/buffer encodings and status bit positions.
// Revision : 1.0
// ============================================================================
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_W   = 3'd1,
    LOAD_INP = 3'd2,
    LOAD_INS = 3'd3,
    LAUNCH   = 3'd4,
    RUN      = 3'd5
  } loader_state_t;

  typedef enum logic [1:0] {
    WEIGHT = 2'd0,
    INPUT  = 2'd1,
    INSTR  = 2'd2
  } buf_sel_t;

  localparam int STATUS_ERR_CMD   = 0;
  localparam int STATUS_ERR_OVF   = 1;
  localparam int STATUS_INS_FULL  = 2;
  localparam int STATUS_INP_FULL  = 3;
  localparam int STATUS_W_FULL    = 4;
  localparam int STATUS_STATE_LSB = 5;

endpackage
`default_nettype wire

// File: rtl/tpu_host_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : tpu_host_loader_if
// Brief    : Host strobes, buffer write port and core handshake of the loader.
// Revision : 1.0
// ============================================================================
interface tpu_host_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();

  logic              fetch_w_i;
  logic              fetch_inp_i;
  logic              fetch_ins_i;
  logic              start_i;
  logic [DATA_W-1:0] data_i;
  logic              mem_we_o;
  logic [1:0]        mem_sel_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              core_start_o;
  logic              core_busy_i;
  logic              core_done_i;
  logic [7:0]        status_o;
  logic [DATA_W-1:0] checksum_o;

  // Host / core side
  modport master (
    output fetch_w_i, fetch_inp_i, fetch_ins_i, start_i, data_i,
    output core_busy_i, core_done_i,
    input  mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    input  core_start_o, status_o, checksum_o
  );

  // Loader side
  modport slave (
    input  fetch_w_i, fetch_inp_i, fetch_ins_i, start_i, data_i,
    input  core_busy_i, core_done_i,
    output mem_we_o, mem_sel_o, mem_addr_o, mem_wdata_o,
    output core_start_o, status_o, checksum_o
  );

endinterface
`default_nettype wire

// File: rtl/tpu_load_ptr.sv
`default_nettype none
// ============================================================================
// Module   : tpu_load_ptr
// Brief    : Per-buffer write pointer with saturating full flag and overflow.
// Revision : 1.0
// ============================================================================
module tpu_load_ptr #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 4
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic              clear,
  input  wire logic              inc,
  output logic [ADDR_W-1:0]      addr,
  output logic                   accept,
  output logic                   ovf,
  output logic                   full
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] r_ptr;
  logic              r_full;
  logic [ADDR_W-1:0] w_eff_ptr;
  logic              w_eff_full;

  // A clear and a byte in the same cycle behave as clear-then-write.
  assign w_eff_ptr  = clear ? '0 : r_ptr;
  assign w_eff_full = clear ? 1'b0 : r_full;

  assign addr   = w_eff_ptr;
  assign accept = inc & ~w_eff_full;
  assign ovf    = inc & w_eff_full;
  assign full   = r_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end else if (accept) begin
      r_full <= (w_eff_ptr == c_last);
      r_ptr  <= (w_eff_ptr == c_last) ? w_eff_ptr : w_eff_ptr + 1'b1;
    end else if (clear) begin
      r_ptr  <= '0;
      r_full <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tpu_host_loader.sv
`default_nettype none
// ============================================================================
// Module   : tpu_host_loader
// Brief    : Streams host bytes into the TPU buffers and launches the core.
//            Optional running XOR checksum: define LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module tpu_host_loader #(
  parameter int DATA_W    = 8,
  parameter int W_DEPTH   = 4,
  parameter int INP_DEPTH = 4,
  parameter int INS_DEPTH = 16,
  parameter int ADDR_W    = 4
) (
  input  wire logic         clk,
  input  wire logic         reset,
  tpu_host_loader_if.slave  bus
);
  import tpu_pkg::*;

  loader_state_t     r_state;
  logic              r_prev_w, r_prev_inp, r_prev_ins, r_prev_start;
  logic              r_err_ovf, r_err_cmd;
  logic              r_mem_we;
  buf_sel_t          r_mem_sel;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_core_start;

  logic w_win_w, w_win_inp, w_win_ins, w_any_fetch, w_multi, w_start_rise, w_loading;
  logic w_enter_w, w_enter_inp, w_enter_ins, w_run_done;
  logic w_acc_w, w_acc_inp, w_acc_ins, w_ovf_w, w_ovf_inp, w_ovf_ins;
  logic w_full_w, w_full_inp, w_full_ins, w_accept, w_ovf;
  logic [ADDR_W-1:0] w_addr_w, w_addr_inp, w_addr_ins, w_wr_addr;
  buf_sel_t          w_wr_sel;
  loader_state_t     w_load_state;
  logic [7:0]        w_status;

  assign w_any_fetch  = bus.fetch_w_i | bus.fetch_inp_i | bus.fetch_ins_i;
  assign w_multi      = $countones({bus.fetch_w_i, bus.fetch_inp_i,
                                    bus.fetch_ins_i, bus.start_i}) > 1;
  assign w_win_w      = bus.fetch_w_i;
  assign w_win_inp    = ~bus.fetch_w_i & bus.fetch_inp_i;
  assign w_win_ins    = ~bus.fetch_w_i & ~bus.fetch_inp_i & bus.fetch_ins_i;
  assign w_start_rise = bus.start_i & ~r_prev_start;
  assign w_loading    = (r_state == IDLE) || (r_state == LOAD_W) ||
                        (r_state == LOAD_INP) || (r_state == LOAD_INS);
  assign w_run_done   = (r_state == RUN) && bus.core_done_i;

  // A load restarts when the winner switches buffer or its strobe re-rises.
  assign w_enter_w   = w_loading & w_win_w   & ((r_state != LOAD_W)   | ~r_prev_w);
  assign w_enter_inp = w_loading & w_win_inp & ((r_state != LOAD_INP) | ~r_prev_inp);
  assign w_enter_ins = w_loading & w_win_ins & ((r_state != LOAD_INS) | ~r_prev_ins);

  tpu_load_ptr #(.DEPTH(W_DEPTH), .ADDR_W(ADDR_W)) u_ptr_w (
    .clk(clk), .reset(reset), .clear(w_enter_w), .inc(w_loading & w_win_w),
    .addr(w_addr_w), .accept(w_acc_w), .ovf(w_ovf_w), .full(w_full_w)
  );

  // Completion releases the activations; weights stay valid for reuse.
  tpu_load_ptr #(.DEPTH(INP_DEPTH), .ADDR_W(ADDR_W)) u_ptr_inp (
    .clk(clk), .reset(reset), .clear(w_enter_inp | w_run_done),
    .inc(w_loading & w_win_inp),
    .addr(w_addr_inp), .accept(w_acc_inp), .ovf(w_ovf_inp), .full(w_full_inp)
  );

  tpu_load_ptr #(.DEPTH(INS_DEPTH), .ADDR_W(ADDR_W)) u_ptr_ins (
    .clk(clk), .reset(reset), .clear(w_enter_ins), .inc(w_loading & w_win_ins),
    .addr(w_addr_ins), .accept(w_acc_ins), .ovf(w_ovf_ins), .full(w_full_ins)
  );

  assign w_accept     = w_acc_w | w_acc_inp | w_acc_ins;
  assign w_ovf        = w_ovf_w | w_ovf_inp | w_ovf_ins;
  assign w_wr_addr    = w_acc_w ? w_addr_w : (w_acc_inp ? w_addr_inp : w_addr_ins);
  assign w_wr_sel     = w_acc_w ? WEIGHT : (w_acc_inp ? INPUT : INSTR);
  assign w_load_state = w_win_w ? LOAD_W : (w_win_inp ? LOAD_INP : LOAD_INS);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_prev_w     <= 1'b0;
      r_prev_inp   <= 1'b0;
      r_prev_ins   <= 1'b0;
      r_prev_start <= 1'b0;
      r_err_ovf    <= 1'b0;
      r_err_cmd    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_sel    <= WEIGHT;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_core_start <= 1'b0;
    end else begin
      r_prev_w     <= bus.fetch_w_i;
      r_prev_inp   <= bus.fetch_inp_i;
      r_prev_ins   <= bus.fetch_ins_i;
      r_prev_start <= bus.start_i;
      r_mem_we     <= 1'b0;
      r_core_start <= 1'b0;
      if (w_multi) r_err_cmd <= 1'b1;
      case (r_state)
        IDLE, LOAD_W, LOAD_INP, LOAD_INS: begin
          if (w_any_fetch) begin
            r_state <= w_load_state;
            if (w_accept) begin
              r_mem_we    <= 1'b1;
              r_mem_sel   <= w_wr_sel;
              r_mem_addr  <= w_wr_addr;
              r_mem_wdata <= bus.data_i;
            end
            if (w_ovf) r_err_ovf <= 1'b1;
          end else if (bus.start_i) begin
            if (w_start_rise) begin
              if (w_full_w && w_full_inp) r_state <= LAUNCH;
              else r_err_cmd <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        LAUNCH: begin
          if (!bus.core_busy_i) begin
            r_core_start <= 1'b1;
            r_state      <= RUN;
          end
        end
        RUN: begin
          if (w_any_fetch) r_err_cmd <= 1'b1;
          if (bus.core_done_i) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    w_status = '0;
    w_status[STATUS_STATE_LSB +: 3] = r_state;
    w_status[STATUS_W_FULL]   = w_full_w;
    w_status[STATUS_INP_FULL] = w_full_inp;
    w_status[STATUS_INS_FULL] = w_full_ins;
    w_status[STATUS_ERR_OVF]  = r_err_ovf;
    w_status[STATUS_ERR_CMD]  = r_err_cmd;
  end

  assign bus.mem_we_o     = r_mem_we;
  assign bus.mem_sel_o    = r_mem_sel;
  assign bus.mem_addr_o   = r_mem_addr;
  assign bus.mem_wdata_o  = r_mem_wdata;
  assign bus.core_start_o = r_core_start;
  assign bus.status_o     = w_status;

`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
  logic              w_enter_any;

  assign w_enter_any = w_enter_w | w_enter_inp | w_enter_ins;

  always_ff @(posedge clk) begin
    if (reset) r_checksum <= '0;
    else if (w_accept) r_checksum <= (w_enter_any ? '0 : r_checksum) ^ bus.data_i;
  end

  assign bus.checksum_o = r_checksum;
`else
  assign bus.checksum_o = '0;
`endif

endmodule
`default_nettype wire

// File: doc/tpu_host_loader.md
Name: tpu_host_loader

Overview:
- Sits directly downstream of the pin-level command decoder in the TPU top.
- Consumes the decoded fetch_w / fetch_inp / fetch_ins / start level strobes and the ui_in data byte.
- Streams host bytes into the weight, input and instruction buffers through one registered write port.
- Launches the compute core with a start/busy/done handshake and reports status back to the pins.

Parameters:
- DATA_W, 8, byte width of ui_in and of each buffer entry.
- W_DEPTH, 4, weight entries (2x2 matrix).
- INP_DEPTH, 4, input-activation entries.
- INS_DEPTH, 16, instruction entries.
- ADDR_W, 4, write-address width; must satisfy 2**ADDR_W >= max depth.

Ports:
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- fetch_w_i  in  1  level; host presents weight bytes.
- fetch_inp_i  in  1  level; host presents input bytes.
- fetch_ins_i  in  1  level; host presents instruction bytes.
- start_i  in  1  level; host requests a run.
- data_i  in  DATA_W  host data byte (ui_in).
- mem_we_o  out  1  buffer write enable.
- mem_sel_o  out  2  target buffer: 0=weight, 1=input, 2=instruction.
- mem_addr_o  out  ADDR_W  write address.
- mem_wdata_o  out  DATA_W  write data.
- core_start_o  out  1  one-cycle launch pulse to the core.
- core_busy_i  in  1  core is running.
- core_done_i  in  1  one-cycle completion pulse from the core.
- status_o  out  8  {state[2:0], w_full, inp_full, ins_full, err_ovf, err_cmd}; drives uio_out.
- checksum_o  out  DATA_W  running XOR (see Optional Feature).

Behaviour:
- Reset: all outputs 0, state IDLE, all pointers 0, all full flags and error flags 0.
  - Reset mid-load or mid-run aborts immediately. Already-written buffer contents are not cleared, but the full flags drop.
- States: IDLE, LOAD_W, LOAD_INP, LOAD_INS, LAUNCH, RUN; encoded 0..5 in status_o[7:5].
- Strobe arbitration:
  - More than one strobe high in a cycle means priority w > inp > ins > start, and err_cmd is set (sticky until reset).
- Entering a load state:
  - From IDLE or any LOAD_* state, when the winning strobe selects a different buffer than the current state, or rises from low: go to LOAD_x and zero that buffer's pointer and its full flag.
- Byte acceptance:
  - In LOAD_x, each cycle with fetch_x high accepts data_i.
  - The next cycle drives mem_we_o=1, mem_sel_o=x, mem_addr_o=ptr, mem_wdata_o=data_i. Write latency is exactly 1 cycle, and the outputs are registered.
  - Then ptr++.
  - When ptr reaches DEPTH_x-1 and is written, full_x=1.
- Overflow:
  - A byte arriving when full_x=1 is dropped (no write, ptr holds) and sets err_ovf (sticky).
  - No wrap-around.
- All strobes low in LOAD_x: return to IDLE. The pointer and full flag are retained.
- start_i rising edge in IDLE or LOAD_x:
  - If w_full and inp_full: go to LAUNCH.
  - Otherwise ignore it and set err_cmd.
  - ins_full is not required; the core executes the written prefix.
- LAUNCH:
  - core_start_o=1 for exactly one cycle, then RUN.
  - If core_busy_i is already high on entry, hold in LAUNCH with core_start_o=0 until busy drops, then pulse.
- RUN:
  - All fetch strobes are ignored; any strobe high sets err_cmd.
  - core_done_i returns to IDLE and clears inp_full. w_full is kept so the weights can be reused.
  - core_done_i outside RUN is ignored.
- start_i held high across done does not relaunch; it needs a fresh rising edge.
- No write is ever issued in LAUNCH or RUN.

Optional Feature:
- Macro: LOADER_CHECKSUM_EN.
- Defined: checksum_o is the XOR of all bytes accepted since the current load began (cleared on load entry and on reset), updated with the same 1-cycle latency as mem_we_o.
- Undefined: checksum_o is constant 0 and no checksum logic is built.

Decomposition:
- Shared package tpu_pkg holds:
  - loader_state_t (3-bit enum of the six states);
  - buf_sel_t (2-bit enum WEIGHT=0, INPUT=1, INSTR=2);
  - STATUS_* bit-index constants.
- One sub-module tpu_load_ptr: per-buffer pointer/full/overflow counter with clear, inc and DEPTH parameter; instantiated three times.

Test Plan:
- Weight load:
  - Stimulus: fetch_w_i high 4 cycles with data 0x11,0x22,0x33,0x44.
  - Response: writes sel=0, addr 0..3 with those values one cycle later; w_full=1; checksum_o=0x44 (with macro).
- Overflow:
  - Stimulus: continue fetch_w_i a 5th cycle with 0x55.
  - Response: no write; err_ovf=1; addr stays 3.
- Launch:
  - Stimulus: load inp 0x01..0x04, then pulse start_i.
  - Response: core_start_o high exactly 1 cycle; state RUN; status_o[7:5]=5.
- Premature start:
  - Stimulus: after reset, assert start_i with nothing loaded.
  - Response: no core_start_o; err_cmd=1; state IDLE.
- Strobes during RUN:
  - Stimulus: fetch_inp_i during RUN, then core_done_i.
  - Response: no writes; err_cmd=1; back to IDLE; inp_full=0, w_full=1.
- Reset mid-load:
  - Stimulus: reset asserted during the 3rd instruction byte.
  - Response: next cycle all outputs 0, state IDLE, ins_full=0.
